// File: rtl/div_pkg.sv
// Shared definitions for the 6-bit restoring divider sequencer and its datapath.
package div_pkg;

    localparam int W     = 6;
    localparam int ITER  = 6;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

endpackage

// File: rtl/cla6_bit.sv
// 6-bit carry-lookahead adder: generate/propagate per bit, carries from c0.
module cla6_bit (
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  logic       c0,
    output logic [5:0] sum,
    output logic       c_out
);

    logic [5:0] g;
    logic [5:0] p;
    logic [6:0] c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = c0;
        for (int unsigned i = 0; i < 6; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum   = p ^ c[5:0];
    assign c_out = c[6];

endmodule

// File: rtl/div6_seq.sv
// Iterative 6-bit unsigned restoring divider: one quotient bit per clock,
// trial subtraction performed by a single cla6_bit instance.
module div6_seq
    import div_pkg::*;
#(
    parameter int W    = div_pkg::W,
    parameter int ITER = div_pkg::ITER
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    div_state_t       state;
    div_state_t       state_nx;
    logic             accept;
    logic             last_iter;

    logic [W:0]       rem_w;
    logic [W-1:0]     quo_w;
    logic [W-1:0]     d_w;
    logic [CNT_W-1:0] cnt;
    logic             dz_w;

    logic [W:0]       s;
    logic [W-1:0]     sum;
    logic             c_out;
    logic             q_bit;
    logic [W:0]       rem_nx;

    assign s      = {rem_w[W-1:0], quo_w[W-1]};
    // S[6] set means S >= 64 > D, so the subtract succeeds regardless of carry.
    assign q_bit  = s[W] | c_out;
    assign rem_nx = q_bit ? {1'b0, sum} : s;

    cla6_bit u_cla (
        .a     (s[W-1:0]),
        .b     (~d_w),
        .c0    (1'b1),
        .sum   (sum),
        .c_out (c_out)
    );

    assign last_iter = (cnt == CNT_W'(ITER - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (dz_w || last_iter) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A zero divisor still spends one cycle in RUN so busy/done timing stays uniform.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_w       <= '0;
            quo_w       <= '0;
            d_w         <= '0;
            cnt         <= '0;
            dz_w        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            rem_w <= '0;
            quo_w <= dividend;
            d_w   <= divisor;
            cnt   <= '0;
            dz_w  <= (divisor == '0);
        end else if (state == RUN) begin
            if (dz_w) begin
                quotient    <= '1;
                remainder   <= quo_w;
                div_by_zero <= 1'b1;
            end else begin
                rem_w <= rem_nx;
                quo_w <= {quo_w[W-2:0], q_bit};
                cnt   <= cnt + 1'b1;
                if (last_iter) begin
                    quotient    <= {quo_w[W-2:0], q_bit};
                    remainder   <= rem_nx[W-1:0];
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_div6_seq.sv
// Directed and exhaustive self-checking bench for div6_seq.
module tb_div6_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] dividend;
    logic [5:0] divisor;
    logic       busy;
    logic       done;
    logic [5:0] quotient;
    logic [5:0] remainder;
    logic       div_by_zero;

    int checks;
    int failures;

    div6_seq #(.W(6), .ITER(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge, then waits (bounded) for done.
    task automatic run_div(input logic [5:0] n, input logic [5:0] d,
                           output int edges, output int busy_cnt);
        dividend = n;
        divisor  = d;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        edges    = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && edges < 20) begin
            tick();
            edges++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        #12;
        rst = 1'b0;
        tick();
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs got b=%0b d=%0b q=%0d r=%0d z=%0b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_basic();
        int edges, bc;
        run_div(6'd45, 6'd7, edges, bc);
        checks++;
        if (edges !== 7) begin
            failures++;
            $display("FAIL basic_latency got %0d want 7", edges);
        end
        checks++;
        if (bc !== 6) begin
            failures++;
            $display("FAIL basic_busy_cycles got %0d want 6", bc);
        end
        checks++;
        if ({done, busy, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 6'd6, 6'd3, 1'b0}) begin
            failures++;
            $display("FAIL basic_45_7 got done=%0b busy=%0b q=%0d r=%0d z=%0b want 1 0 6 3 0",
                     done, busy, quotient, remainder, div_by_zero);
        end
        tick();
        checks++;
        if ({done, quotient, remainder} !== {1'b0, 6'd6, 6'd3}) begin
            failures++;
            $display("FAIL basic_hold got done=%0b q=%0d r=%0d want 0 6 3", done, quotient, remainder);
        end
    endtask

    task automatic test_vectors();
        logic [5:0] vn [4] = '{6'd63, 6'd5, 6'd63, 6'd62};
        logic [5:0] vd [4] = '{6'd1,  6'd9, 6'd63, 6'd32};
        logic [5:0] vq [4] = '{6'd63, 6'd0, 6'd1,  6'd1};
        logic [5:0] vr [4] = '{6'd0,  6'd5, 6'd0,  6'd30};
        int edges, bc;
        for (int i = 0; i < 4; i++) begin
            run_div(vn[i], vd[i], edges, bc);
            checks++;
            if ({done, quotient, remainder, div_by_zero} !== {1'b1, vq[i], vr[i], 1'b0}) begin
                failures++;
                $display("FAIL vec_%0d_%0d got done=%0b q=%0d r=%0d z=%0b want 1 %0d %0d 0",
                         vn[i], vd[i], done, quotient, remainder, div_by_zero, vq[i], vr[i]);
            end
        end
        tick();
    endtask

    task automatic test_div_zero();
        int edges, bc;
        run_div(6'd40, 6'd0, edges, bc);
        checks++;
        if (edges !== 2 || bc !== 1) begin
            failures++;
            $display("FAIL dz_latency got edges=%0d busy=%0d want 2 1", edges, bc);
        end
        checks++;
        if ({done, quotient, remainder, div_by_zero} !== {1'b1, 6'd63, 6'd40, 1'b1}) begin
            failures++;
            $display("FAIL dz_result got done=%0b q=%0d r=%0d z=%0b want 1 63 40 1",
                     done, quotient, remainder, div_by_zero);
        end
        tick();
        checks++;
        if ({done, div_by_zero, remainder} !== {1'b0, 1'b1, 6'd40}) begin
            failures++;
            $display("FAIL dz_hold got done=%0b z=%0b r=%0d want 0 1 40", done, div_by_zero, remainder);
        end
        run_div(6'd8, 6'd3, edges, bc);
        checks++;
        if ({done, quotient, remainder, div_by_zero} !== {1'b1, 6'd2, 6'd2, 1'b0}) begin
            failures++;
            $display("FAIL dz_clear got done=%0b q=%0d r=%0d z=%0b want 1 2 2 0",
                     done, quotient, remainder, div_by_zero);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int done_edges [$];
        dividend = 6'd20;
        divisor  = 6'd3;
        start    = 1'b1;
        tick();
        // operands change right after acceptance; start stays high through RUN
        dividend = 6'd50;
        divisor  = 6'd6;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (done) done_edges.push_back(e);
            if (e == 6) begin
                checks++;
                if ({done, busy, quotient, remainder} !== {1'b1, 1'b0, 6'd6, 6'd2}) begin
                    failures++;
                    $display("FAIL b2b_first got done=%0b busy=%0b q=%0d r=%0d want 1 0 6 2",
                             done, busy, quotient, remainder);
                end
            end
            if (e == 7) begin
                checks++;
                if ({done, busy} !== 2'b01) begin
                    failures++;
                    $display("FAIL b2b_reaccept got done=%0b busy=%0b want 0 1", done, busy);
                end
            end
            if (e == 13) begin
                start = 1'b0;
                checks++;
                if ({done, quotient, remainder} !== {1'b1, 6'd8, 6'd2}) begin
                    failures++;
                    $display("FAIL b2b_second got done=%0b q=%0d r=%0d want 1 8 2",
                             done, quotient, remainder);
                end
            end
        end
        checks++;
        if (done_edges.size() !== 2) begin
            failures++;
            $display("FAIL b2b_done_count got %0d want 2", done_edges.size());
        end
    endtask

    task automatic test_reset_mid();
        int edges, bc;
        int late_done;
        dividend = 6'd45;
        divisor  = 6'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            failures++;
            $display("FAIL midrst_outputs got b=%0b d=%0b q=%0d r=%0d z=%0b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        tick();
        rst = 1'b0;
        late_done = 0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (done || busy) late_done++;
        end
        checks++;
        if (late_done !== 0) begin
            failures++;
            $display("FAIL midrst_no_done got %0d active cycles want 0", late_done);
        end
        run_div(6'd9, 6'd4, edges, bc);
        checks++;
        if ({done, quotient, remainder, div_by_zero} !== {1'b1, 6'd2, 6'd1, 1'b0}) begin
            failures++;
            $display("FAIL midrst_after got done=%0b q=%0d r=%0d z=%0b want 1 2 1 0",
                     done, quotient, remainder, div_by_zero);
        end
        tick();
    endtask

    task automatic test_exhaustive();
        int edges, bc;
        logic [12:0] got, want;
        for (int n = 0; n < 64; n++) begin
            for (int d = 0; d < 64; d++) begin
                run_div(6'(n), 6'(d), edges, bc);
                if (d == 0) want = {1'b1, 6'd63, 6'(n)};
                else        want = {1'b0, 6'(n / d), 6'(n % d)};
                got = {div_by_zero, quotient, remainder};
                checks++;
                if (!done || got !== want) begin
                    failures++;
                    $display("FAIL exh_%0d_%0d got done=%0b z=%0b q=%0d r=%0d want z=%0b q=%0d r=%0d",
                             n, d, done, got[12], got[11:6], got[5:0], want[12], want[11:6], want[5:0]);
                end
            end
        end
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_vectors();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
